// File: rtl/guineveer_mem_pkg.sv
// == guineveer_mem_pkg : shared request/response types and index helper for the SRAM arbiter (rev 1.0) ==
`default_nettype none

package guineveer_mem_pkg;

  localparam int NUM_REQ_DEF    = 2;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int STRB_WIDTH_DEF = DATA_WIDTH_DEF / 8;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic                      we;
    logic [STRB_WIDTH_DEF-1:0] strb;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] rdata;
  } mem_rsp_t;

  // Never returns zero so a single-entry index still has a usable bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_WIDTH = idx_width(NUM_REQ_DEF);
  typedef logic [IDX_WIDTH-1:0] idx_t;

endpackage

`default_nettype wire

// File: rtl/guineveer_mem_route_fifo.sv
// == guineveer_mem_route_fifo : in-order FIFO of requester indices for response steering (rev 1.0) ==
`default_nettype none

module guineveer_mem_route_fifo
  import guineveer_mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_o  = slots[rd_ptr];
  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      slots[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop_i) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push_i && !pop_i) begin
        count <= count + 1'b1;
      end else if (pop_i && !push_i) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/guineveer_mem_arbiter.sv
// == guineveer_mem_arbiter : round-robin single-port SRAM arbiter with in-order response routing (rev 1.0) ==
`default_nettype none

module guineveer_mem_arbiter
  import guineveer_mem_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 2,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*STRB_WIDTH-1:0] strb_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_we_o,
  output logic [STRB_WIDTH-1:0]         mem_strb_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  output logic                          err_o
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   head;
  logic [NUM_REQ-1:0] eligible;
  logic               fifo_full;
  logic               fifo_empty;
  logic               full_eff;
  logic               pop;
  logic               handshake;

  // A response in this cycle frees a slot, so a full FIFO can still accept.
  assign pop       = mem_rvalid_i && !fifo_empty;
  assign full_eff  = fifo_full && !pop;
  assign eligible  = req_i & {NUM_REQ{!full_eff}};
  assign mem_req_o = |eligible;
  assign handshake = mem_req_o && mem_gnt_i;
  assign rdata_o   = mem_rdata_i;

  // Lowest eligible index at/above rr_ptr wins; otherwise lowest below it (wrap).
  always_comb begin : select
    logic [IDX_W-1:0] win_hi;
    logic [IDX_W-1:0] win_lo;
    logic             found_hi;
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (IDX_W'(i) >= rr_ptr) begin
          win_hi   = IDX_W'(i);
          found_hi = 1'b1;
        end else begin
          win_lo = IDX_W'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_strb_o  = '0;
    mem_wdata_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        mem_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_we_o    = we_i[i];
        mem_strb_o  = strb_i[i*STRB_WIDTH +: STRB_WIDTH];
        mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_onehot
    assign gnt_o[i]    = handshake && (winner == IDX_W'(i));
    assign rvalid_o[i] = pop && (head == IDX_W'(i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (mem_rvalid_i && fifo_empty) begin
      err_o <= 1'b1;
    end
  end

  guineveer_mem_route_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (winner),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_guineveer_mem_arbiter.sv
// == tb_guineveer_mem_arbiter : directed tables, corner sequences and randomized model check (rev 1.0) ==
`default_nettype none

module tb_guineveer_mem_arbiter;
  import guineveer_mem_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int MO = 2;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [N*AW-1:0] addr_i;
  logic [N-1:0]    we_i;
  logic [N*SW-1:0] strb_i;
  logic [N*DW-1:0] wdata_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            mem_req_o;
  logic            mem_gnt_i;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_we_o;
  logic [SW-1:0]   mem_strb_o;
  logic [DW-1:0]   mem_wdata_o;
  logic            mem_rvalid_i;
  logic [DW-1:0]   mem_rdata_i;
  logic            err_o;

  mem_req_t rq [N];

  for (genvar i = 0; i < N; i++) begin : g_fields
    assign addr_i[i*AW +: AW]  = rq[i].addr;
    assign we_i[i]             = rq[i].we;
    assign strb_i[i*SW +: SW]  = rq[i].strb;
    assign wdata_i[i*DW +: DW] = rq[i].wdata;
  end

  always #5 clk = ~clk;

  guineveer_mem_arbiter #(
    .NUM_REQ         (N),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .strb_i       (strb_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_strb_o   (mem_strb_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .err_o        (err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] req;
    logic       g;
    logic       rv;
    logic [1:0] e_gnt;
    logic [1:0] e_rv;
    logic       e_mreq;
    logic       e_err;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [1:0] req, input logic g, input logic rv,
                              input logic [1:0] e_gnt, input logic [1:0] e_rv,
                              input logic e_mreq, input logic e_err);
    vec_t v;
    v.req = req; v.g = g; v.rv = rv;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_mreq = e_mreq; v.e_err = e_err;
    return v;
  endfunction

  // One clock: drive, settle, compare, then step to 1 time unit past the edge.
  task automatic cyc(input logic [1:0] req, input logic g, input logic rv,
                     input logic [1:0] e_gnt, input logic [1:0] e_rv,
                     input logic e_mreq, input logic e_err, input string tag);
    req_i = req; mem_gnt_i = g; mem_rvalid_i = rv;
    #2;
    chk({tag, ".gnt"},     gnt_o,     e_gnt);
    chk({tag, ".rvalid"},  rvalid_o,  e_rv);
    chk({tag, ".mem_req"}, mem_req_o, e_mreq);
    chk({tag, ".err"},     err_o,     e_err);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1; req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #2;
    chk({tag, ".rst_gnt"},     gnt_o,     '0);
    chk({tag, ".rst_rvalid"},  rvalid_o,  '0);
    chk({tag, ".rst_mem_req"}, mem_req_o, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk({tag, ".rst_err"}, err_o, 1'b0);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [SW-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) begin
      if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic mem_req_t rnd_req();
    mem_req_t r;
    r.addr  = $urandom;
    r.we    = 1'($urandom_range(0, 1));
    r.strb  = 8'($urandom);
    r.wdata = {$urandom, $urandom};
    return r;
  endfunction

  // Reference model state for the random phase.
  int   q [$];
  int   rr;
  logic merr;

  initial begin
    logic [DW-1:0] word;
    rst_i = 1'b1; req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < N; i++) begin
      rq[i] = '{addr: AW'(32'h100 * (i + 1)), we: 1'b0, strb: '1, wdata: '0};
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    // Round robin, backpressure and spurious response, 1-cycle SRAM.
    tbl.push_back(mk(2'b11, 1, 0, 2'b01, 2'b00, 1, 0));
    tbl.push_back(mk(2'b11, 1, 1, 2'b10, 2'b01, 1, 0));
    tbl.push_back(mk(2'b11, 1, 1, 2'b01, 2'b10, 1, 0));
    tbl.push_back(mk(2'b11, 1, 1, 2'b10, 2'b01, 1, 0));
    tbl.push_back(mk(2'b00, 1, 1, 2'b00, 2'b10, 0, 0));
    tbl.push_back(mk(2'b01, 0, 0, 2'b00, 2'b00, 1, 0));
    tbl.push_back(mk(2'b01, 0, 0, 2'b00, 2'b00, 1, 0));
    tbl.push_back(mk(2'b01, 0, 0, 2'b00, 2'b00, 1, 0));
    tbl.push_back(mk(2'b01, 1, 0, 2'b01, 2'b00, 1, 0));
    tbl.push_back(mk(2'b00, 0, 1, 2'b00, 2'b01, 0, 0));
    tbl.push_back(mk(2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(2'b10, 1, 0, 2'b10, 2'b00, 1, 1));
    tbl.push_back(mk(2'b00, 0, 1, 2'b00, 2'b10, 0, 1));
    foreach (tbl[k]) begin
      cyc(tbl[k].req, tbl[k].g, tbl[k].rv, tbl[k].e_gnt, tbl[k].e_rv,
          tbl[k].e_mreq, tbl[k].e_err, $sformatf("tbl%0d", k));
    end

    // FIFO full with 4-cycle SRAM: stall until the first response, then push+pop.
    do_reset("full");
    cyc(2'b11, 1, 0, 2'b01, 2'b00, 1, 0, "full.c0");
    cyc(2'b11, 1, 0, 2'b10, 2'b00, 1, 0, "full.c1");
    cyc(2'b11, 1, 0, 2'b00, 2'b00, 0, 0, "full.c2");
    cyc(2'b11, 1, 0, 2'b00, 2'b00, 0, 0, "full.c3");
    cyc(2'b11, 1, 1, 2'b01, 2'b01, 1, 0, "full.c4");
    cyc(2'b11, 1, 1, 2'b10, 2'b10, 1, 0, "full.c5");

    // Write from requester 1 then read from requester 0 to the same word.
    do_reset("wr");
    rq[1] = '{addr: 32'h10, we: 1'b1, strb: 8'h0F, wdata: 64'h1122334455667788};
    rq[0] = '{addr: 32'h10, we: 1'b0, strb: 8'hFF, wdata: '0};
    word  = merge('0, rq[1].wdata, rq[1].strb);
    req_i = 2'b10; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    #2;
    chk("wr.mem_we",    mem_we_o,    1'b1);
    chk("wr.mem_addr",  mem_addr_o,  32'h10);
    chk("wr.mem_strb",  mem_strb_o,  8'h0F);
    chk("wr.mem_wdata", mem_wdata_o, 64'h1122334455667788);
    cyc(2'b10, 1, 0, 2'b10, 2'b00, 1, 0, "wr.c0");
    cyc(2'b01, 1, 1, 2'b01, 2'b10, 1, 0, "wr.c1");
    mem_rdata_i = word;
    req_i = 2'b00; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #2;
    chk("wr.rdata_lo", rdata_o[31:0], 32'h55667788);
    cyc(2'b00, 0, 1, 2'b00, 2'b01, 0, 0, "wr.c2");
    mem_rdata_i = '0;

    // Reset with two entries outstanding and rr_ptr pointing at requester 1.
    do_reset("mid");
    cyc(2'b11, 1, 0, 2'b01, 2'b00, 1, 0, "mid.c0");
    cyc(2'b11, 1, 0, 2'b10, 2'b00, 1, 0, "mid.c1");
    cyc(2'b11, 1, 1, 2'b01, 2'b01, 1, 0, "mid.c2");
    do_reset("mid");
    cyc(2'b00, 0, 1, 2'b00, 2'b00, 0, 0, "mid.late");
    cyc(2'b11, 1, 0, 2'b01, 2'b00, 1, 1, "mid.first");

    // Randomized traffic against the queue-based reference model.
    do_reset("rnd");
    q.delete(); rr = 0; merr = 1'b0;
    for (int i = 0; i < N; i++) rq[i] = rnd_req();
    req_i = '0;
    for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
      logic [N-1:0] nreq;
      logic         pop_m, full_m, hs;
      int           win;
      logic [N-1:0] e_gnt, e_rv, elig;
      mem_gnt_i    = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata_i  = {$urandom, $urandom};
      pop_m  = mem_rvalid_i && (q.size() > 0);
      full_m = (q.size() == MO) && !pop_m;
      elig   = full_m ? '0 : req_i;
      win    = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && elig[(rr + k) % N]) win = (rr + k) % N;
      end
      hs    = (win >= 0) && mem_gnt_i;
      e_gnt = hs ? N'(1 << win) : '0;
      e_rv  = pop_m ? N'(1 << q[0]) : '0;
      #2;
      chk("rnd.gnt",     gnt_o,     e_gnt);
      chk("rnd.rvalid",  rvalid_o,  e_rv);
      chk("rnd.mem_req", mem_req_o, win >= 0);
      chk("rnd.err",     err_o,     merr);
      chk("rnd.rdata",   rdata_o,   mem_rdata_i);
      if (win >= 0) begin
        chk("rnd.addr",  mem_addr_o,  rq[win].addr);
        chk("rnd.we",    mem_we_o,    rq[win].we);
        chk("rnd.strb",  mem_strb_o,  rq[win].strb);
        chk("rnd.wdata", mem_wdata_o, rq[win].wdata);
      end
      if (pop_m) void'(q.pop_front());
      if (hs) begin
        q.push_back(win);
        rr = (win + 1) % N;
      end
      nreq = req_i;
      for (int i = 0; i < N; i++) begin
        if (hs && win == i) begin
          nreq[i] = 1'b0;
          rq[i]   = rnd_req();
        end
        if (!nreq[i] && $urandom_range(0, 2) != 0) nreq[i] = 1'b1;
      end
      @(posedge clk); #1;
      req_i = nreq;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
